// File: rtl/pc_unit.sv
// Program-counter unit: next-PC select, trap entry/return,
// target-misalignment redirect and a circular return-address stack.
module pc_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100),
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            areset,
  input  logic            load,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] imm_ext,
  input  logic [XLEN-1:0] rs1,
  input  logic            ras_push,
  input  logic            trap,
  input  logic            trap_ret,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] epc,
  output logic            misalign,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            mis_q, mis_d;
  logic [PW-1:0]   top_q, top_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];

  logic            ras_we;
  logic [PW-1:0]   ras_wa;
  logic [XLEN-1:0] tgt;
  logic            pop;
  logic            empty;
  logic            full;

  assign pc_plus4  = pc_q + XLEN'(4);
  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CW'(RAS_DEPTH));
  assign pop       = (pc_src == 2'd3);

  assign pc        = pc_q;
  assign epc       = epc_q;
  assign misalign  = mis_q;
  assign ras_empty = empty;
  assign ras_full  = full;

  // Candidate target; an empty stack falls back to the sequential PC.
  always_comb begin
    tgt = pc_plus4;
    unique case (pc_src)
      2'd0: tgt = pc_plus4;
      2'd1: tgt = pc_q + imm_ext;
      2'd2: tgt = (rs1 + imm_ext) & ~XLEN'(1);
      default: tgt = empty ? pc_plus4 : ras_q[top_q];
    endcase
  end

  // Prioritised next-state: trap, trap return, misaligned redirect, normal.
  always_comb begin
    pc_d   = pc_q;
    epc_d  = epc_q;
    mis_d  = 1'b0;
    top_d  = top_q;
    cnt_d  = cnt_q;
    ras_we = 1'b0;
    ras_wa = top_q;
    if (load) begin
      if (trap) begin
        pc_d  = TRAP_VEC;
        epc_d = pc_q;
      end else if (trap_ret) begin
        pc_d = epc_q;
      end else if (tgt[1:0] != 2'b00) begin
        pc_d  = TRAP_VEC;
        epc_d = pc_q;
        mis_d = 1'b1;
      end else begin
        pc_d = tgt;
        if (ras_push && pop && !empty) begin
          // Return and call together: replace the top in place.
          ras_we = 1'b1;
          ras_wa = top_q;
        end else if (ras_push) begin
          ras_we = 1'b1;
          ras_wa = top_q + PW'(1);
          top_d  = top_q + PW'(1);
          if (!full) cnt_d = cnt_q + CW'(1);
        end else if (pop && !empty) begin
          top_d = top_q - PW'(1);
          cnt_d = cnt_q - CW'(1);
        end
      end
    end
  end

  // Architectural state with asynchronous reset.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      pc_q  <= RESET_VEC;
      epc_q <= '0;
      mis_q <= 1'b0;
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      mis_q <= mis_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end

  // Stack storage; contents are meaningless until counted in.
  always_ff @(posedge clk) begin
    if (ras_we) ras_q[ras_wa] <= pc_plus4;
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: expected states are queued
// as stimulus is driven and compared after each update.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        areset = 1'b0;
  logic        load = 1'b0;
  logic [1:0]  pc_src = 2'd0;
  logic [31:0] imm_ext = '0;
  logic [31:0] rs1 = '0;
  logic        ras_push = 1'b0;
  logic        trap = 1'b0;
  logic        trap_ret = 1'b0;
  logic [31:0] pc, pc_plus4, epc;
  logic        misalign, ras_empty, ras_full;

  pc_unit #(
    .XLEN(32),
    .RESET_VEC(32'h0),
    .TRAP_VEC(32'h100),
    .RAS_DEPTH(4)
  ) dut (
    .clk(clk),
    .areset(areset),
    .load(load),
    .pc_src(pc_src),
    .imm_ext(imm_ext),
    .rs1(rs1),
    .ras_push(ras_push),
    .trap(trap),
    .trap_ret(trap_ret),
    .pc(pc),
    .pc_plus4(pc_plus4),
    .epc(epc),
    .misalign(misalign),
    .ras_empty(ras_empty),
    .ras_full(ras_full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        mis;
    logic        emp;
    logic        full;
  } obs_t;

  typedef struct {
    logic        ld;
    logic [1:0]  src;
    logic [31:0] imm;
    logic [31:0] r;
    logic        psh;
    logic        tr;
    logic        trt;
    obs_t        e;
  } step_t;

  obs_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic obs_t sample();
    obs_t o;
    o.pc   = pc;
    o.epc  = epc;
    o.mis  = misalign;
    o.emp  = ras_empty;
    o.full = ras_full;
    return o;
  endfunction

  function automatic step_t st(
    logic ld, logic [1:0] src, logic [31:0] imm, logic [31:0] r,
    logic psh, logic tr, logic trt,
    logic [31:0] epc_v, logic [31:0] epcx, logic m, logic em, logic fu);
    step_t s;
    s.ld = ld; s.src = src; s.imm = imm; s.r = r;
    s.psh = psh; s.tr = tr; s.trt = trt;
    s.e.pc = epc_v; s.e.epc = epcx;
    s.e.mis = m; s.e.emp = em; s.e.full = fu;
    return s;
  endfunction

  task automatic apply(input step_t s);
    load = s.ld; pc_src = s.src; imm_ext = s.imm; rs1 = s.r;
    ras_push = s.psh; trap = s.tr; trap_ret = s.trt;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t g, w;
    areset = 1'b0;
    #2;
    exp_q.push_back('{32'h0, 32'h0, 1'b0, 1'b1, 1'b0});
    g = sample(); w = exp_q.pop_front(); n_chk++;
    if (g !== w) $display("FAIL reset got=%h want=%h", g, w);
    else n_pass++;
    n_chk++;
    if (pc_plus4 !== 32'h4) $display("FAIL reset_pc4 got=%h want=4", pc_plus4);
    else n_pass++;
    @(negedge clk);
    areset = 1'b1;
  endtask

  task automatic test_seq();
    step_t s[$];
    obs_t g, w;
    s.push_back(st(1, 0, 0, 0, 0, 0, 0, 32'h4, 0, 0, 1, 0));
    s.push_back(st(1, 0, 0, 0, 0, 0, 0, 32'h8, 0, 0, 1, 0));
    s.push_back(st(1, 0, 0, 0, 0, 0, 0, 32'hC, 0, 0, 1, 0));
    foreach (s[i]) begin
      exp_q.push_back(s[i].e);
      apply(s[i]);
      g = sample(); w = exp_q.pop_front(); n_chk++;
      if (g !== w) $display("FAIL seq[%0d] got=%h want=%h", i, g, w);
      else n_pass++;
    end
    n_chk++;
    if (pc_plus4 !== 32'h10) $display("FAIL seq_pc4 got=%h want=10", pc_plus4);
    else n_pass++;
  endtask

  task automatic test_branch();
    step_t s[$];
    obs_t g, w;
    s.push_back(st(1, 1, 32'h34, 0, 0, 0, 0, 32'h40, 0, 0, 1, 0));
    s.push_back(st(1, 1, 32'hFFFF_FFF0, 0, 0, 0, 0, 32'h30, 0, 0, 1, 0));
    s.push_back(st(1, 2, 32'h3, 32'h201, 0, 0, 0, 32'h204, 0, 0, 1, 0));
    foreach (s[i]) begin
      exp_q.push_back(s[i].e);
      apply(s[i]);
      g = sample(); w = exp_q.pop_front(); n_chk++;
      if (g !== w) $display("FAIL branch[%0d] got=%h want=%h", i, g, w);
      else n_pass++;
    end
  endtask

  task automatic test_misalign();
    step_t s[$];
    obs_t g, w;
    s.push_back(st(1, 1, 32'hFFFF_FE0C, 0, 0, 0, 0, 32'h10, 0, 0, 1, 0));
    s.push_back(st(1, 1, 32'h2, 0, 1, 0, 0, 32'h100, 32'h10, 1, 1, 0));
    s.push_back(st(0, 0, 0, 0, 0, 0, 0, 32'h100, 32'h10, 0, 1, 0));
    s.push_back(st(1, 0, 0, 0, 0, 0, 1, 32'h10, 32'h10, 0, 1, 0));
    foreach (s[i]) begin
      exp_q.push_back(s[i].e);
      apply(s[i]);
      g = sample(); w = exp_q.pop_front(); n_chk++;
      if (g !== w) $display("FAIL misalign[%0d] got=%h want=%h", i, g, w);
      else n_pass++;
    end
  endtask

  task automatic test_ras();
    step_t s[$];
    obs_t g, w;
    s.push_back(st(1, 1, 32'hFFFF_FFF0, 0, 0, 0, 0, 32'h0, 32'h10, 0, 1, 0));
    s.push_back(st(1, 0, 0, 0, 1, 0, 0, 32'h4, 32'h10, 0, 0, 0));
    s.push_back(st(1, 0, 0, 0, 1, 0, 0, 32'h8, 32'h10, 0, 0, 0));
    s.push_back(st(1, 0, 0, 0, 1, 0, 0, 32'hC, 32'h10, 0, 0, 0));
    s.push_back(st(1, 0, 0, 0, 1, 0, 0, 32'h10, 32'h10, 0, 0, 1));
    s.push_back(st(1, 0, 0, 0, 1, 0, 0, 32'h14, 32'h10, 0, 0, 1));
    s.push_back(st(1, 3, 0, 0, 0, 0, 0, 32'h14, 32'h10, 0, 0, 0));
    s.push_back(st(1, 3, 0, 0, 0, 0, 0, 32'h10, 32'h10, 0, 0, 0));
    s.push_back(st(1, 3, 0, 0, 0, 0, 0, 32'hC, 32'h10, 0, 0, 0));
    s.push_back(st(1, 3, 0, 0, 0, 0, 0, 32'h8, 32'h10, 0, 1, 0));
    s.push_back(st(1, 3, 0, 0, 0, 0, 0, 32'hC, 32'h10, 0, 1, 0));
    foreach (s[i]) begin
      exp_q.push_back(s[i].e);
      apply(s[i]);
      g = sample(); w = exp_q.pop_front(); n_chk++;
      if (g !== w) $display("FAIL ras[%0d] got=%h want=%h", i, g, w);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    step_t s[$];
    obs_t g, w;
    s.push_back(st(1, 3, 0, 0, 1, 0, 0, 32'h10, 32'h10, 0, 0, 0));
    s.push_back(st(1, 3, 0, 0, 1, 0, 0, 32'h10, 32'h10, 0, 0, 0));
    s.push_back(st(1, 3, 0, 0, 0, 0, 0, 32'h14, 32'h10, 0, 1, 0));
    s.push_back(st(1, 2, 0, 32'h80, 1, 0, 0, 32'h80, 32'h10, 0, 0, 0));
    foreach (s[i]) begin
      exp_q.push_back(s[i].e);
      apply(s[i]);
      g = sample(); w = exp_q.pop_front(); n_chk++;
      if (g !== w) $display("FAIL b2b[%0d] got=%h want=%h", i, g, w);
      else n_pass++;
    end
  endtask

  task automatic test_trap();
    step_t s[$];
    obs_t g, w;
    s.push_back(st(1, 3, 0, 0, 1, 1, 0, 32'h100, 32'h80, 0, 0, 0));
    s.push_back(st(0, 3, 32'h2, 0, 1, 1, 1, 32'h100, 32'h80, 0, 0, 0));
    s.push_back(st(0, 1, 32'h6, 0, 1, 1, 0, 32'h100, 32'h80, 0, 0, 0));
    s.push_back(st(0, 2, 0, 32'h7, 1, 0, 1, 32'h100, 32'h80, 0, 0, 0));
    s.push_back(st(1, 3, 0, 0, 0, 0, 0, 32'h18, 32'h80, 0, 1, 0));
    foreach (s[i]) begin
      exp_q.push_back(s[i].e);
      apply(s[i]);
      g = sample(); w = exp_q.pop_front(); n_chk++;
      if (g !== w) $display("FAIL trap[%0d] got=%h want=%h", i, g, w);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    step_t s[$];
    obs_t g, w;
    s.push_back(st(1, 1, 32'h1EC, 0, 1, 0, 0, 32'h204, 32'h80, 0, 0, 0));
    s.push_back(st(1, 1, 32'h0, 0, 1, 0, 0, 32'h204, 32'h80, 0, 0, 0));
    foreach (s[i]) begin
      exp_q.push_back(s[i].e);
      apply(s[i]);
      g = sample(); w = exp_q.pop_front(); n_chk++;
      if (g !== w) $display("FAIL areset_pre[%0d] got=%h want=%h", i, g, w);
      else n_pass++;
    end
    #2;
    areset = 1'b0;
    #1;
    exp_q.push_back('{32'h0, 32'h0, 1'b0, 1'b1, 1'b0});
    g = sample(); w = exp_q.pop_front(); n_chk++;
    if (g !== w) $display("FAIL areset_async got=%h want=%h", g, w);
    else n_pass++;
    load = 1'b1; pc_src = 2'd0; ras_push = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back('{32'h0, 32'h0, 1'b0, 1'b1, 1'b0});
    g = sample(); w = exp_q.pop_front(); n_chk++;
    if (g !== w) $display("FAIL areset_hold got=%h want=%h", g, w);
    else n_pass++;
    @(negedge clk);
    areset = 1'b1;
    load = 1'b0; ras_push = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_seq();
    test_branch();
    test_misalign();
    test_ras();
    test_back_to_back();
    test_trap();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
